// File: rtl/cnn_pkg.sv
// Shared CNN constants and types; l4_tx uses the result geometry, sync byte and FSM encoding.
package cnn_pkg;
  localparam int         L4_N_OUT  = 64;
  localparam int         L4_DW     = 18;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {IDLE, HDR, SEND, DONE, REARM} l4_tx_state_t;
endpackage

// File: rtl/l4_tx_fmt.sv
// Maps a held result word and a byte index to the outgoing byte.
// Byte 0 is the sign-extended top slice, then the two low bytes MSB first.
module l4_tx_fmt #(
  parameter int DW = 18
) (
  input  logic [DW-1:0] hold_i,
  input  logic [1:0]    byte_cnt_i,
  output logic [7:0]    byte_o
);
  logic [7:0] b0;

  generate
    if (DW < 24) begin : g_ext
      assign b0 = {{(24-DW){hold_i[DW-1]}}, hold_i[DW-1:16]};
    end else begin : g_full
      assign b0 = hold_i[23:16];
    end
  endgenerate

  always_comb begin
    byte_o = b0;
    case (byte_cnt_i)
      2'd0:    byte_o = b0;
      2'd1:    byte_o = hold_i[15:8];
      default: byte_o = hold_i[7:0];
    endcase
  end
endmodule

// File: rtl/l4_tx.sv
// Streams layer 4's result frame (sync byte + 3 bytes/word) to a byte transmitter,
// then pulses tx_done so layer 4 can re-arm.
module l4_tx import cnn_pkg::*; #(
  parameter int         DW        = L4_DW,
  parameter int         N_WORDS   = L4_N_OUT,
  parameter logic [7:0] SYNC_BYTE = cnn_pkg::SYNC_BYTE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         strt,
  input  logic [N_WORDS-1:0][DW-1:0]   din,
  input  logic                         tx_rdy,
  output logic                         tx_vld,
  output logic [7:0]                   tx_byte,
  output logic                         tx_done
);
  localparam int WCW = $clog2(N_WORDS);
  localparam logic [WCW-1:0] LAST_W = WCW'(N_WORDS - 1);

  l4_tx_state_t   state_q;
  logic [WCW-1:0] word_cnt_q;
  logic [1:0]     byte_cnt_q;
  logic [DW-1:0]  hold_q;
  logic           tx_vld_q, tx_done_q;
  logic [7:0]     tx_byte_q;

  logic           xfer, capture;
  logic [WCW-1:0] cap_idx;
  logic [DW-1:0]  fmt_hold;
  logic [1:0]     fmt_bcnt;
  logic [7:0]     nxt_byte;

  assign xfer = tx_vld_q & tx_rdy;

  // The next byte is formatted ahead of the transfer: either a freshly captured
  // word's b0 straight from din, or the following byte of the held word.
  assign capture  = (state_q == HDR) || (byte_cnt_q == 2'd2);
  assign cap_idx  = (state_q == HDR) ? '0 : word_cnt_q + 1'b1;
  assign fmt_hold = capture ? din[cap_idx] : hold_q;
  assign fmt_bcnt = capture ? 2'd0 : byte_cnt_q + 2'd1;

  l4_tx_fmt #(.DW(DW)) u_fmt (
    .hold_i     (fmt_hold),
    .byte_cnt_i (fmt_bcnt),
    .byte_o     (nxt_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      hold_q     <= '0;
      tx_vld_q   <= 1'b0;
      tx_byte_q  <= 8'h00;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        IDLE: if (strt) begin
          tx_byte_q <= SYNC_BYTE;
          tx_vld_q  <= 1'b1;
          state_q   <= HDR;
        end
        HDR: if (xfer) begin
          hold_q     <= fmt_hold;
          tx_byte_q  <= nxt_byte;
          word_cnt_q <= '0;
          byte_cnt_q <= '0;
          state_q    <= SEND;
        end
        SEND: if (xfer) begin
          if (byte_cnt_q < 2'd2) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            tx_byte_q  <= nxt_byte;
          end else if (word_cnt_q < LAST_W) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            byte_cnt_q <= '0;
            hold_q     <= fmt_hold;
            tx_byte_q  <= nxt_byte;
          end else begin
            // Pulse lands in the cycle right after the last transfer.
            tx_vld_q  <= 1'b0;
            tx_done_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          word_cnt_q <= '0;
          byte_cnt_q <= '0;
          state_q    <= REARM;
        end
        REARM: if (!strt) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_vld  = tx_vld_q;
  assign tx_byte = tx_byte_q;
  assign tx_done = tx_done_q;
endmodule

// File: tb/tb_l4_tx.sv
// Directed bench for l4_tx: frame content, sign extension, backpressure,
// word capture, re-arm behaviour and mid-frame reset.
module tb_l4_tx;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               strt = 1'b0;
  logic               tx_rdy = 1'b1;
  logic [63:0][17:0]  din;
  logic               tx_vld, tx_done;
  logic [7:0]         tx_byte;

  int          n_chk = 0, n_fail = 0;
  int          n_done = 0, cyc = 0, last_xfer = 0, done_cyc = 0;
  bit          rdy_rand = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_byte = 8'h00;
  logic [7:0]  q[$];
  logic [63:0][17:0] img;

  l4_tx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .strt    (strt),
    .din     (din),
    .tx_rdy  (tx_rdy),
    .tx_vld  (tx_vld),
    .tx_byte (tx_byte),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] eb(input logic [17:0] v, input int b);
    case (b)
      0:       eb = {{6{v[17]}}, v[17:16]};
      1:       eb = v[15:8];
      default: eb = v[7:0];
    endcase
  endfunction

  task automatic check_frame(input string tag, input logic [63:0][17:0] im);
    int nerr = 0;
    logic [7:0] e;
    chk({tag, "_len"}, q.size(), 193);
    for (int i = 0; i < q.size() && i < 193; i++) begin
      e = (i == 0) ? 8'hA5 : eb(im[(i-1)/3], (i-1)%3);
      if (q[i] !== e) nerr++;
    end
    chk({tag, "_bytes_bad"}, nerr, 0);
  endtask

  // Waits for the next tx_done; optionally rewrites din[3] once w3's b0 has gone out.
  task automatic wait_done(input int chg_at);
    int  d0 = n_done;
    bit  hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      tick();
      if (chg_at > 0 && q.size() >= chg_at) begin
        din[3] = 18'h2ABCD;
        chg_at = 0;
      end
      if (n_done != d0) hit = 1'b1;
    end
    chk("done_seen", hit, 1);
  endtask

  task automatic set_ramp();
    for (int w = 0; w < 64; w++) din[w] = 18'(w);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    tx_rdy = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  // Observes transfers and the done pulse away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_vld", tx_vld, 1);
        chk("stall_byte", tx_byte, prev_byte);
      end
      if (tx_vld && tx_rdy) begin
        q.push_back(tx_byte);
        last_xfer = cyc;
      end
      if (tx_done) begin
        n_done++;
        done_cyc = cyc;
      end
      prev_stall = tx_vld && !tx_rdy;
      prev_byte  = tx_byte;
    end
  end

  initial begin
    int d;
    set_ramp();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_vld", tx_vld, 0);
    chk("rst_byte", tx_byte, 8'h00);
    chk("rst_done", tx_done, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: ramp frame, tx_rdy held high
    img = din;
    q.delete();
    strt = 1'b1;
    @(negedge clk);
    chk("vld_pre", tx_vld, 0);
    @(negedge clk);
    chk("vld_lat", tx_vld, 1);
    chk("vld_sync", tx_byte, 8'hA5);
    wait_done(0);
    strt = 1'b0;
    chk("t1_b0", q[0], 8'hA5);
    chk("t1_b1", q[1], 8'h00);
    chk("t1_b2", q[2], 8'h00);
    chk("t1_b3", q[3], 8'h00);
    chk("t1_b6", q[6], 8'h01);
    chk("t1_b190", q[190], 8'h00);
    chk("t1_b191", q[191], 8'h00);
    chk("t1_b192", q[192], 8'h3F);
    chk("t1_done_lat", done_cyc - last_xfer, 1);
    check_frame("t1", img);
    repeat (3) tick();
    chk("t1_done_cnt", n_done, 1);

    // 2: sign extension
    din[5] = 18'h3FFFF;
    din[6] = 18'h20000;
    img = din;
    q.delete();
    strt = 1'b1;
    wait_done(0);
    strt = 1'b0;
    chk("t2_w5b0", q[16], 8'hFF);
    chk("t2_w5b1", q[17], 8'hFF);
    chk("t2_w5b2", q[18], 8'hFF);
    chk("t2_w6b0", q[19], 8'hFE);
    chk("t2_w6b1", q[20], 8'h00);
    chk("t2_w6b2", q[21], 8'h00);
    check_frame("t2", img);
    repeat (3) tick();

    // 3: random backpressure, same ramp stream
    set_ramp();
    img = din;
    q.delete();
    rdy_rand = 1'b1;
    strt = 1'b1;
    wait_done(0);
    strt = 1'b0;
    rdy_rand = 1'b0;
    check_frame("t3", img);
    repeat (3) tick();

    // 4: din changes after w3's b0 went out; held word must be used
    set_ramp();
    img = din;
    q.delete();
    strt = 1'b1;
    wait_done(11);
    strt = 1'b0;
    chk("t4_w3b0", q[10], 8'h00);
    chk("t4_w3b1", q[11], 8'h00);
    chk("t4_w3b2", q[12], 8'h03);
    check_frame("t4", img);
    set_ramp();
    repeat (3) tick();

    // 5: stale strt after done must not restart
    img = din;
    q.delete();
    strt = 1'b1;
    wait_done(0);
    d = n_done;
    repeat (5) begin
      @(negedge clk);
      chk("t5_no_vld", tx_vld, 0);
    end
    chk("t5_len_hold", q.size(), 193);
    chk("t5_no_done", n_done, d);
    tick();
    strt = 1'b0;
    tick();
    tick();
    q.delete();
    strt = 1'b1;
    wait_done(0);
    strt = 1'b0;
    check_frame("t5", img);
    repeat (3) tick();

    // 6: reset at byte 100, then a clean full frame
    q.delete();
    d = n_done;
    strt = 1'b1;
    for (int i = 0; i < 1000 && q.size() < 100; i++) tick();
    chk("t6_reached", q.size(), 100);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_vld", tx_vld, 0);
    chk("t6_rst_byte", tx_byte, 8'h00);
    chk("t6_rst_done", tx_done, 0);
    strt = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t6_no_done", n_done, d);
    q.delete();
    strt = 1'b1;
    wait_done(0);
    strt = 1'b0;
    chk("t6_first", q[0], 8'hA5);
    check_frame("t6", img);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
